// File: rtl/mips_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient for LO, remainder for HI, with sign fix-up in a final cycle.
module mips_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] prem, qacc, dsr;
  logic [CW-1:0]    cnt;
  logic             sgn, neg_a, neg_b, dz;

  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;

  assign abs_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The partial remainder never exceeds the divisor after a restore, so the
  // WIDTH+1 bit view is only needed transiently for the trial subtraction.
  assign shifted = {prem, qacc[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};

  // A zero divisor leaves |a| in the remainder; re-applying the dividend sign
  // restores the raw dividend, so only the quotient needs forcing.
  assign q_fix = dz ? '1 : ((sgn && (neg_a ^ neg_b)) ? -qacc : qacc);
  assign r_fix = (sgn && neg_a) ? -prem : prem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      prem        <= '0;
      qacc        <= '0;
      dsr         <= '0;
      sgn         <= 1'b0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      dz          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // The done cycle also accepts a launch, giving back-to-back issue
        // every WIDTH+2 clocks.
        IDLE, DONE: begin
          if (start) begin
            sgn   <= is_signed;
            neg_a <= is_signed & dividend[WIDTH-1];
            neg_b <= is_signed & divisor[WIDTH-1];
            dz    <= (divisor == '0);
            qacc  <= abs_a;
            dsr   <= abs_b;
            prem  <= '0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            prem <= trial[WIDTH-1:0];
            qacc <= {qacc[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH-1:0];
            qacc <= {qacc[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dz;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit: directed cases, protocol/reset
// scenarios and randomized operations against an arithmetic model.
module tb_mips_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, is_signed;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  // Results of the last do_op
  logic [W-1:0] oq, orr;
  logic         odz, overlap;
  int           olat, obusy;

  // Truncating division; remainder follows the dividend sign.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, b,
                                  output logic [W-1:0] q, r, output logic dz);
    longint sa, sb;
    dz = (b == 0);
    if (dz) begin
      q = '1; r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Launch one operation and wait (bounded) for done.
  task automatic do_op(input logic s, input logic [W-1:0] a, b);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    obusy = busy ? 1 : 0;
    olat  = 0;
    @(negedge clk);
    start = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
    while (!done && olat < 60) begin
      @(posedge clk); #1;
      olat++;
      if (busy) obusy++;
      if (busy && done) overlap = 1'b1;
    end
    oq = quotient; orr = remainder; odz = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 100; divisor = 7;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got q=%h r=%h dz=%b want zeros", quotient, remainder, div_by_zero);
    end
    @(negedge clk); reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_unsigned();
    do_op(1'b0, 100, 7);
    checks++; if (olat !== 33) begin errors++; $display("FAIL u_latency got %0d want 33", olat); end
    checks++; if (oq !== 14) begin errors++; $display("FAIL u_quotient got %0d want 14", oq); end
    checks++; if (orr !== 2) begin errors++; $display("FAIL u_remainder got %0d want 2", orr); end
    checks++; if (obusy !== 33) begin errors++; $display("FAIL u_busy_cycles got %0d want 33", obusy); end
  endtask

  task automatic test_signed();
    do_op(1'b1, 32'hFFFFFFF9, 2);
    checks++; if (oq !== 32'hFFFFFFFD || orr !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL s_neg7_div2 got q=%h r=%h want q=fffffffd r=ffffffff", oq, orr);
    end
    do_op(1'b1, 7, 32'hFFFFFFFE);
    checks++; if (oq !== 32'hFFFFFFFD || orr !== 1) begin
      errors++; $display("FAIL s_7_divneg2 got q=%h r=%h want q=fffffffd r=1", oq, orr);
    end
  endtask

  task automatic test_boundaries();
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
    checks++; if (oq !== 32'h80000000 || orr !== 0 || odz !== 1'b0) begin
      errors++; $display("FAIL s_overflow got q=%h r=%h dz=%b want 80000000 0 0", oq, orr, odz);
    end
    do_op(1'b0, 32'hFFFFFFFF, 1);
    checks++; if (oq !== 32'hFFFFFFFF || orr !== 0) begin
      errors++; $display("FAIL u_max_div1 got q=%h r=%h want ffffffff 0", oq, orr);
    end
  endtask

  task automatic test_div_by_zero();
    do_op(1'b1, 1234, 0);
    checks++; if (olat !== 33) begin errors++; $display("FAIL dz_latency got %0d want 33", olat); end
    checks++; if (oq !== 32'hFFFFFFFF || orr !== 1234 || odz !== 1'b1) begin
      errors++; $display("FAIL dz_result got q=%h r=%0d dz=%b want ffffffff 1234 1", oq, orr, odz);
    end
    do_op(1'b1, 0, 5);
    checks++; if (oq !== 0 || orr !== 0 || odz !== 1'b0) begin
      errors++; $display("FAIL dz_clear got q=%h r=%h dz=%b want 0 0 0", oq, orr, odz);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic s, edz;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = ($urandom_range(0, 1) != 0) ? -W'($urandom_range(1, 15)) : W'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h1;
      endcase
      do_op(s, a, b);
      ref_div(s, a, b, eq, er, edz);
      checks++; if (oq !== eq || orr !== er || odz !== edz || olat !== 33) begin
        errors++;
        $display("FAIL rand_%0d s=%b a=%h b=%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=33",
                 i, s, a, b, oq, orr, odz, olat, eq, er, edz);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk); start = 1'b1; is_signed = 1'b0; dividend = 100; divisor = 7;
    @(posedge clk);                              // E0
    repeat (9) @(posedge clk);                   // E9
    @(negedge clk); start = 1'b1; dividend = 1000; divisor = 3;
    @(posedge clk);                              // E10, must be ignored
    cyc = 10;
    @(negedge clk); start = 1'b0;
    while (!done && cyc < 60) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== 33 || quotient !== 14 || remainder !== 2) begin
      errors++; $display("FAIL ignore_start got cyc=%0d q=%0d r=%0d want 33 14 2", cyc, quotient, remainder);
    end
    @(negedge clk); start = 1'b1; is_signed = 1'b0; dividend = 50; divisor = 5;
    @(posedge clk); #1;                          // E34
    cyc = 34;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
    end
    @(negedge clk); start = 1'b0;
    while (!done && cyc < 90) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 50) begin
        checks++; if (quotient !== 14 || remainder !== 2) begin
          errors++; $display("FAIL hold_outputs got q=%0d r=%0d want 14 2", quotient, remainder);
        end
      end
    end
    checks++; if (cyc !== 67 || quotient !== 10 || remainder !== 0) begin
      errors++; $display("FAIL b2b_done got cyc=%0d q=%0d r=%0d want 67 10 0", cyc, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk); start = 1'b1; is_signed = 1'b0; dividend = 100; divisor = 7;
    @(posedge clk);                              // E0
    @(negedge clk); start = 1'b0;
    repeat (14) @(posedge clk);                  // E14
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;                          // E15
    checks++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL mid_reset got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                         busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_done got done pulse want none"); end
    do_op(1'b0, 9, 3);
    checks++; if (oq !== 3 || orr !== 0 || olat !== 33) begin
      errors++; $display("FAIL after_reset got q=%0d r=%0d lat=%0d want 3 0 33", oq, orr, olat);
    end
  endtask

  initial begin
    overlap = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_boundaries();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL busy_done_overlap got 1 want 0"); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
